// File: rtl/issue_scoreboard_pkg.sv
// Shared widths and request bundle for the issue scoreboard and its register banks.
package issue_scoreboard_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 64;
  localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [NW_BITS-1:0] wid_t;
  typedef logic [NR_BITS-1:0] reg_t;

  typedef struct packed {
    wid_t wid;
    logic wb;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    reg_t rs3;
    logic use_rs3;
  } scoreboard_req_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Instruction-buffer, operand-fetch and writeback signals around the issue scoreboard.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic ibuf_valid;
  logic ibuf_ready;
  wid_t ibuf_wid;
  logic ibuf_wb;
  reg_t ibuf_rd;
  reg_t ibuf_rs1;
  reg_t ibuf_rs2;
  reg_t ibuf_rs3;
  logic ibuf_use_rs3;
  logic issue_valid;
  logic issue_ready;
  logic wb_valid;
  wid_t wb_wid;
  reg_t wb_rd;
  logic wb_eop;
  logic stall_timeout;
  logic wb_error;

  // The master is the surrounding pipeline; the slave is the scoreboard itself.
  modport master (
    output ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_use_rs3,
    output issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
    input  ibuf_ready, issue_valid, stall_timeout, wb_error
  );

  modport slave (
    input  ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_use_rs3,
    input  issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
    output ibuf_ready, issue_valid, stall_timeout, wb_error
  );

endinterface

// File: rtl/issue_scoreboard_bank.sv
// One warp's in-use vector: a set port, a clear port and combinational read ports.
module scoreboard_bank
  import issue_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic set_en,
  input  reg_t set_reg,
  input  logic clr_en,
  input  reg_t clr_reg,
  input  reg_t rs1,
  input  reg_t rs2,
  input  reg_t rs3,
  input  reg_t rd,
  output logic rs1_busy,
  output logic rs2_busy,
  output logic rs3_busy,
  output logic rd_busy,
  output logic clr_busy
);

  logic [NUM_REGS-1:0] inuse;

  // Set is applied after clear so it wins on a collision; x0 is never marked busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      inuse <= '0;
    end else begin
      if (clr_en) inuse[clr_reg] <= 1'b0;
      if (set_en && (set_reg != '0)) inuse[set_reg] <= 1'b1;
    end
  end

  assign rs1_busy = inuse[rs1];
  assign rs2_busy = inuse[rs2];
  assign rs3_busy = inuse[rs3];
  assign rd_busy  = inuse[rd];
  assign clr_busy = inuse[clr_reg];

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard gate: holds an instruction while any of its operands or its destination
// has an outstanding write in the same warp, and releases bits on the final writeback packet.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int STALL_TIMEOUT = 100000
) (
  input logic clk,
  input logic reset,
  issue_scoreboard_if.slave sb
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(STALL_TIMEOUT);

  scoreboard_req_t req;
  logic [NUM_WARPS-1:0] rs1_busy, rs2_busy, rs3_busy, rd_busy, clr_busy;
  logic hazard, fire, stall, wb_commit;
  logic [CW-1:0] stall_cnt, stall_cnt_next;
  logic stall_timeout_q, wb_error_q;

  assign req = '{wid: sb.ibuf_wid, wb: sb.ibuf_wb, rd: sb.ibuf_rd, rs1: sb.ibuf_rs1,
                 rs2: sb.ibuf_rs2, rs3: sb.ibuf_rs3, use_rs3: sb.ibuf_use_rs3};

  assign wb_commit = sb.wb_valid & sb.wb_eop;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    scoreboard_bank u_bank (
      .clk      (clk),
      .reset    (reset),
      .set_en   (fire && req.wb && (req.wid == wid_t'(w))),
      .set_reg  (req.rd),
      .clr_en   (wb_commit && (sb.wb_wid == wid_t'(w))),
      .clr_reg  (sb.wb_rd),
      .rs1      (req.rs1),
      .rs2      (req.rs2),
      .rs3      (req.rs3),
      .rd       (req.rd),
      .rs1_busy (rs1_busy[w]),
      .rs2_busy (rs2_busy[w]),
      .rs3_busy (rs3_busy[w]),
      .rd_busy  (rd_busy[w]),
      .clr_busy (clr_busy[w])
    );
  end

  // Hazard looks only at registered state, so a release becomes visible one cycle later.
  assign hazard = rs1_busy[req.wid] | rs2_busy[req.wid]
                | (req.use_rs3 & rs3_busy[req.wid])
                | (req.wb & rd_busy[req.wid]);

  assign sb.issue_valid = sb.ibuf_valid & ~hazard;
  assign sb.ibuf_ready  = sb.issue_ready & ~hazard;
  assign fire           = sb.ibuf_valid & sb.issue_ready & ~hazard;
  assign stall          = sb.ibuf_valid & hazard;

  // Only hazard stalls count; any other cycle restarts the count.
  always_comb begin
    stall_cnt_next = '0;
    if (stall) begin
      stall_cnt_next = (stall_cnt == TIMEOUT_VAL) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt       <= '0;
      stall_timeout_q <= 1'b0;
      wb_error_q      <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      if (stall && (stall_cnt_next == TIMEOUT_VAL)) stall_timeout_q <= 1'b1;
      if (wb_commit && !clr_busy[sb.wb_wid] && (sb.wb_rd != '0)) wb_error_q <= 1'b1;
    end
  end

  assign sb.stall_timeout = stall_timeout_q;
  assign sb.wb_error      = wb_error_q;

  // A legal pipeline never issues a write to a register whose final writeback commits now.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fire && req.wb && (req.rd != '0) && wb_commit &&
                (sb.wb_wid == req.wid) && (sb.wb_rd == req.rd)));
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected outputs are queued with each stimulus and
// compared by an independent monitor on the falling clock edge.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int TIMEOUT = 20;

  typedef struct {
    string name;
    logic [3:0] outs;
  } exp_t;

  logic clk;
  logic reset;
  int tests_run;
  int tests_failed;
  exp_t exp_q[$];
  exp_t cur;

  issue_scoreboard_if sb_if ();

  issue_scoreboard #(.STALL_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: {issue_valid,ibuf_ready,stall_timeout,wb_error} got %b expected %b",
               name, actual, expected);
    end
  endtask

  task automatic driveIssue(input logic valid, input logic [1:0] wid, input logic wb,
                            input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                            input logic [5:0] rs3, input logic use_rs3, input logic ready);
    sb_if.ibuf_valid   = valid;
    sb_if.ibuf_wid     = wid;
    sb_if.ibuf_wb      = wb;
    sb_if.ibuf_rd      = rd;
    sb_if.ibuf_rs1     = rs1;
    sb_if.ibuf_rs2     = rs2;
    sb_if.ibuf_rs3     = rs3;
    sb_if.ibuf_use_rs3 = use_rs3;
    sb_if.issue_ready  = ready;
  endtask

  task automatic driveWb(input logic valid, input logic [1:0] wid, input logic [5:0] rd, input logic eop);
    sb_if.wb_valid = valid;
    sb_if.wb_wid   = wid;
    sb_if.wb_rd    = rd;
    sb_if.wb_eop   = eop;
  endtask

  // Queue the expectation for this cycle (if requested), then advance one clock.
  task automatic applyStimulus(input string name, input bit chk, input logic e_iv, input logic e_ir,
                               input logic e_st, input logic e_we);
    exp_t e;
    if (chk) begin
      e.name = name;
      e.outs = {e_iv, e_ir, e_st, e_we};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput(cur.name, {sb_if.issue_valid, sb_if.ibuf_ready, sb_if.stall_timeout, sb_if.wb_error},
                  cur.outs);
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    driveIssue(0, 0, 0, 0, 0, 0, 0, 0, 1);
    driveWb(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus("reset_idle", 1, 0, 1, 0, 0);

    // RAW on wid0 r5
    driveIssue(1, 0, 1, 5, 1, 2, 3, 0, 1);
    applyStimulus("t1_issue_rd5", 1, 1, 1, 0, 0);
    driveIssue(1, 0, 0, 0, 5, 2, 3, 0, 1);
    applyStimulus("t1_raw_stall", 1, 0, 0, 0, 0);

    // Non-eop packet does nothing; eop frees r5 only from the next cycle
    driveWb(1, 0, 5, 0);
    applyStimulus("t2_noeop", 1, 0, 0, 0, 0);
    driveWb(1, 0, 5, 1);
    applyStimulus("t2_eop_same_cycle", 1, 0, 0, 0, 0);
    driveWb(0, 0, 0, 0);
    applyStimulus("t2_after_eop", 1, 1, 1, 0, 0);

    // Per-warp isolation and operand-select corners
    driveIssue(1, 0, 1, 5, 1, 2, 3, 0, 1);
    applyStimulus("t3_reissue_rd5", 1, 1, 1, 0, 0);
    driveIssue(1, 1, 0, 0, 5, 2, 3, 0, 1);
    applyStimulus("t3_other_warp", 1, 1, 1, 0, 0);
    driveIssue(1, 0, 0, 0, 1, 5, 3, 0, 1);
    applyStimulus("t3_rs2_hazard", 1, 0, 0, 0, 0);
    driveIssue(1, 0, 0, 0, 1, 2, 5, 0, 1);
    applyStimulus("t3_rs3_unused", 1, 1, 1, 0, 0);
    driveIssue(1, 0, 0, 0, 1, 2, 5, 1, 1);
    applyStimulus("t3_rs3_used", 1, 0, 0, 0, 0);
    driveIssue(1, 0, 1, 5, 1, 2, 3, 0, 1);
    applyStimulus("t3_waw", 1, 0, 0, 0, 0);
    driveIssue(1, 0, 0, 5, 1, 2, 3, 0, 1);
    applyStimulus("t3_rd_no_wb", 1, 1, 1, 0, 0);

    // x0 is never tracked
    driveIssue(1, 2, 1, 0, 1, 2, 3, 0, 1);
    applyStimulus("t4_issue_x0", 1, 1, 1, 0, 0);
    driveIssue(1, 2, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus("t4_read_x0", 1, 1, 1, 0, 0);

    // Backpressure without a hazard never counts toward the timeout
    driveIssue(1, 2, 0, 0, 1, 2, 3, 0, 0);
    for (int i = 1; i <= 5 * TIMEOUT; i++) begin
      applyStimulus("t5_backpressure", (i % 10) == 0, 1, 0, 0, 0);
    end

    // Hazard stall on wid0 r5 held until the timeout trips
    driveIssue(1, 0, 0, 0, 5, 2, 3, 0, 1);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      if (i == TIMEOUT) applyStimulus("t5_before_timeout", 1, 0, 0, 0, 0);
      else if (i == TIMEOUT + 1) applyStimulus("t5_timeout", 1, 0, 0, 1, 0);
      else applyStimulus("t5_stall", 0, 0, 0, 0, 0);
    end
    driveWb(1, 0, 5, 1);
    applyStimulus("t5_release", 1, 0, 0, 1, 0);
    driveWb(0, 0, 0, 0);
    applyStimulus("t5_sticky", 1, 1, 1, 1, 0);

    // Eop writeback to a free register raises the sticky error
    driveIssue(0, 0, 0, 0, 0, 0, 0, 0, 1);
    driveWb(1, 2, 7, 1);
    applyStimulus("t6_bad_wb_cycle", 1, 0, 1, 1, 0);
    driveWb(0, 0, 0, 0);
    applyStimulus("t6_wb_error", 1, 0, 1, 1, 1);

    // Concurrent set of wid3 r9 and clear of wid3 r4
    driveIssue(1, 3, 1, 4, 1, 2, 3, 0, 1);
    applyStimulus("t6_set_r4", 1, 1, 1, 1, 1);
    driveIssue(1, 3, 1, 9, 1, 2, 3, 0, 1);
    driveWb(1, 3, 4, 1);
    applyStimulus("t6_set_and_clear", 1, 1, 1, 1, 1);
    driveWb(0, 0, 0, 0);
    driveIssue(1, 3, 0, 0, 9, 2, 3, 0, 1);
    applyStimulus("t6_r9_busy", 1, 0, 0, 1, 1);
    driveIssue(1, 3, 0, 0, 4, 2, 3, 0, 1);
    applyStimulus("t6_r4_free", 1, 1, 1, 1, 1);

    // Reset mid-operation drops outstanding bits and both sticky flags
    driveIssue(0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    applyStimulus("rst_mid", 0, 0, 0, 0, 0);
    reset = 1'b0;
    driveIssue(1, 3, 0, 0, 9, 2, 3, 0, 1);
    applyStimulus("rst_cleared", 1, 1, 1, 0, 0);

    driveIssue(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: pending expectations %0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
